// File: rtl/pwm_multi_channel_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pwm_multi_channel_if: config and duty-write bus of the PWM block  |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
interface pwm_multi_channel_if #(
  parameter int NUM_CH = 16,
  parameter int CNT_W  = 8,
  parameter int DIV_W  = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] en_out;
  logic [NUM_CH-1:0] en_pwm;
  logic              duty_wr;
  logic [CH_W-1:0]   duty_wr_ch;
  logic [CNT_W-1:0]  duty_wdata;
  logic [CNT_W-1:0]  period;
  logic [DIV_W-1:0]  prescale;
  logic              center_mode;

  modport master (
    output en_out, en_pwm, duty_wr, duty_wr_ch, duty_wdata, period, prescale, center_mode
  );

  modport slave (
    input en_out, en_pwm, duty_wr, duty_wr_ch, duty_wdata, period, prescale, center_mode
  );
endinterface
`default_nettype wire

// File: rtl/pwm_multi_channel.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pwm_multi_channel: NUM_CH double-buffered PWM channels sharing one |
// | prescaled edge/center-aligned counter.                 rev 1.0    |
// +------------------------------------------------------------------+
module pwm_multi_channel #(
  parameter int NUM_CH = 16,
  parameter int CNT_W  = 8,
  parameter int DIV_W  = 8
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  pwm_multi_channel_if.slave bus,
  output logic [NUM_CH-1:0]  out,
  output logic               period_tick
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic [DIV_W-1:0]  pre_cnt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  period_act;
  logic              mode_act;
  dir_t              dir;
  logic              tick;
  logic              boundary;
  logic              wr_ok;
  logic [CNT_W:0]    cnt_inc;
  logic [NUM_CH-1:0] out_nxt;

  assign tick    = (pre_cnt == bus.prescale);
  assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
  assign wr_ok   = bus.duty_wr && (32'(bus.duty_wr_ch) < NUM_CH);

  always_comb begin
    boundary = 1'b0;
    if (tick) begin
      if (mode_act)
        boundary = ((dir == DIR_DOWN) && (cnt <= CNT_W'(1))) || (period_act == '0);
      else
        boundary = (cnt >= period_act);
    end
  end

  // The 9-bit increment keeps the center-mode turn-around free of overflow at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt     <= '0;
      cnt         <= '0;
      dir         <= DIR_UP;
      period_act  <= bus.period;
      mode_act    <= bus.center_mode;
      period_tick <= 1'b0;
    end else begin
      period_tick <= boundary;
      pre_cnt     <= tick ? '0 : pre_cnt + DIV_W'(1);
      if (boundary) begin
        cnt        <= '0;
        dir        <= DIR_UP;
        period_act <= bus.period;
        mode_act   <= bus.center_mode;
      end else if (tick) begin
        if (!mode_act) begin
          cnt <= cnt_inc[CNT_W-1:0];
        end else if (dir == DIR_UP) begin
          if (cnt_inc >= {1'b0, period_act}) begin
            cnt <= period_act;
            dir <= DIR_DOWN;
          end else begin
            cnt <= cnt_inc[CNT_W-1:0];
          end
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] active;
    logic             wr_hit;

    assign wr_hit     = wr_ok && (32'(bus.duty_wr_ch) == i);
    assign out_nxt[i] = bus.en_out[i] & (~bus.en_pwm[i] | (cnt < active));

    // A write landing on the boundary goes straight into the active copy.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        shadow <= '0;
        active <= '0;
      end else begin
        if (wr_hit)
          shadow <= bus.duty_wdata;
        if (boundary)
          active <= wr_hit ? bus.duty_wdata : shadow;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      out <= '0;
    else
      out <= out_nxt;
  end
endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_channel.sv
`default_nettype none
// tb_pwm_multi_channel: directed and random stimulus, scoreboard fed by a
// period-position reference model of the PWM.
module tb_pwm_multi_channel;
  localparam int NUM_CH = 12;
  localparam int CNT_W  = 8;
  localparam int DIV_W  = 8;
  localparam int CH_W   = $clog2(NUM_CH);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] out;
  logic              period_tick;

  pwm_multi_channel_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_W(DIV_W)) bus();

  pwm_multi_channel #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .out         (out),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef logic [NUM_CH:0] exp_t;
  exp_t exp_q[$];

  // Reference state: position inside the current period plus the loaded config.
  int m_pre, m_pos, m_pact;
  bit m_mode;
  int m_shadow[NUM_CH];
  int m_active[NUM_CH];
  logic [NUM_CH-1:0] m_eo;
  bit m_tick, m_bnd;
  int m_c, m_idx;

  function automatic int m_len();
    if (!m_mode) return m_pact + 1;
    return (m_pact == 0) ? 1 : 2 * m_pact;
  endfunction

  function automatic int m_cnt();
    if (!m_mode) return m_pos;
    return (m_pos <= m_pact) ? m_pos : 2 * m_pact - m_pos;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pre  = 0;
      m_pos  = 0;
      m_pact = int'(bus.period);
      m_mode = bus.center_mode;
      for (int i = 0; i < NUM_CH; i++) begin
        m_shadow[i] = 0;
        m_active[i] = 0;
      end
      exp_q.push_back('0);
    end else begin
      m_c = m_cnt();
      for (int i = 0; i < NUM_CH; i++)
        m_eo[i] = bus.en_out[i] & (~bus.en_pwm[i] | ((m_c < m_active[i]) ? 1'b1 : 1'b0));
      m_tick = (m_pre == int'(bus.prescale));
      m_bnd  = m_tick && (m_pos == m_len() - 1);
      m_pre  = m_tick ? 0 : (m_pre + 1) % (1 << DIV_W);
      if (m_tick) m_pos = m_bnd ? 0 : m_pos + 1;
      m_idx = int'(bus.duty_wr_ch);
      if (bus.duty_wr && m_idx < NUM_CH) m_shadow[m_idx] = int'(bus.duty_wdata);
      if (m_bnd) begin
        for (int i = 0; i < NUM_CH; i++) m_active[i] = m_shadow[i];
        m_pact = int'(bus.period);
        m_mode = bus.center_mode;
      end
      exp_q.push_back({m_eo, m_bnd});
    end
  end

  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_total++;
      if ({out, period_tick} === mon_e) n_pass++;
      else $display("FAIL scoreboard t=%0t: out=%h tick=%b, expected out=%h tick=%b",
                    $time, out, period_tick, mon_e[NUM_CH:1], mon_e[0]);
    end
  end

  task automatic check(string name, int act, int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic write_duty(int ch, int val);
    bus.duty_wr    = 1'b1;
    bus.duty_wr_ch = CH_W'(ch);
    bus.duty_wdata = CNT_W'(val);
    @(negedge clk);
    bus.duty_wr    = 1'b0;
  endtask

  task automatic sync_tick(string name);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (period_tick !== 1'b1 && k < 2000);
    if (period_tick !== 1'b1) begin
      n_total++;
      $display("FAIL %s: no period_tick within 2000 cycles, got 0 expected 1", name);
    end
  endtask

  // Starts on a negedge where period_tick is high; counts one full period.
  task automatic measure(string name, int ch, int exp_high, int exp_len);
    int len = 0;
    int high = 0;
    do begin
      high += (out[ch] === 1'b1) ? 1 : 0;
      len++;
      @(negedge clk);
    end while (period_tick !== 1'b1 && len < 2000);
    check({name, "_high"}, high, exp_high);
    check({name, "_len"}, len, exp_len);
  endtask

  initial begin
    bus.en_out      = '0;
    bus.en_pwm      = '0;
    bus.duty_wr     = 1'b0;
    bus.duty_wr_ch  = '0;
    bus.duty_wdata  = '0;
    bus.period      = 8'd255;
    bus.prescale    = '0;
    bus.center_mode = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out", int'(out), 0);
    check("reset_tick", int'(period_tick), 0);
    rst_n = 1'b1;

    // Edge mode, 256-cycle period, half duty on ch0.
    bus.en_out[0] = 1'b1;
    bus.en_pwm[0] = 1'b1;
    write_duty(0, 128);
    sync_tick("first_tick");
    sync_tick("second_tick");
    measure("edge128", 0, 128, 256);

    // Mid-period write only shows up one period later.
    fork
      measure("edge128_hold", 0, 128, 256);
      begin
        repeat (9) @(negedge clk);
        write_duty(0, 64);
      end
    join
    measure("edge64", 0, 64, 256);

    // Write landing exactly on the boundary takes effect in that new period.
    repeat (255) @(negedge clk);
    write_duty(0, 32);
    measure("edge32_on_b", 0, 32, 256);

    // Zero duty, then duty above period.
    bus.en_out[3] = 1'b1;
    bus.en_pwm[3] = 1'b1;
    write_duty(3, 0);
    sync_tick("ch3_zero_sync");
    measure("ch3_zero", 3, 0, 256);
    bus.period = 8'd99;
    write_duty(3, 200);
    sync_tick("ch3_full_sync1");
    sync_tick("ch3_full_sync2");
    measure("ch3_full", 3, 100, 100);

    // Center-aligned triangle 0..4..1.
    bus.center_mode = 1'b1;
    bus.period      = 8'd4;
    bus.en_out[1]   = 1'b1;
    bus.en_pwm[1]   = 1'b1;
    write_duty(1, 2);
    sync_tick("center_sync1");
    sync_tick("center_sync2");
    measure("center_ch1", 1, 3, 8);

    // Prescaled edge mode and an out-of-range duty write.
    bus.center_mode = 1'b0;
    bus.period      = 8'd9;
    bus.prescale    = 8'd3;
    write_duty(15, 7);
    sync_tick("presc_sync1");
    sync_tick("presc_sync2");
    measure("presc_ch0", 0, 40, 40);
    measure("presc_ch1", 1, 8, 40);

    // Static-high channel and a mid-period reset.
    bus.en_out[5] = 1'b1;
    bus.en_pwm[5] = 1'b0;
    @(negedge clk);
    check("static_ch5", int'(out[5]), 1);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_out", int'(out), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_out", int'(out), 32'h20);

    // Randomized segments.
    for (int s = 0; s < 25; s++) begin
      bus.prescale    = DIV_W'($urandom_range(0, 2));
      bus.period      = CNT_W'($urandom_range(0, 12));
      bus.center_mode = 1'($urandom_range(0, 1));
      bus.en_out      = NUM_CH'($urandom);
      bus.en_pwm      = NUM_CH'($urandom);
      for (int c = 0; c < 120; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.duty_wr    = 1'b1;
          bus.duty_wr_ch = CH_W'($urandom_range(0, 15));
          bus.duty_wdata = CNT_W'($urandom_range(0, 15));
        end else begin
          bus.duty_wr = 1'b0;
        end
        rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
        @(negedge clk);
      end
    end
    bus.duty_wr = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
